// File: rtl/minterm_scan_engine.sv
// Sequential truth-table engine: sweeps all 2**N_VARS input rows in binary or Gray order,
// evaluates N_FUNCS minterm-mask functions per row and accumulates per-function minterm counts.
module minterm_scan_engine #(
    parameter int N_VARS  = 3,
    parameter int N_FUNCS = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            gray_mode,
    input  logic                            hold,
    input  logic [N_FUNCS*(2**N_VARS)-1:0]  func_mask,
    output logic                            busy,
    output logic                            row_valid,
    output logic [N_VARS-1:0]               row_in,
    output logic [N_FUNCS-1:0]              row_out,
    output logic                            done,
    output logic [N_FUNCS*(N_VARS+1)-1:0]   ones_count,
    output logic [N_FUNCS-1:0]              taut,
    output logic [N_FUNCS-1:0]              unsat
);

    localparam int ROWS = 2**N_VARS;
    localparam int CW   = N_VARS + 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
    localparam logic [CW-1:0] FULL     = CW'(ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;

    logic [N_FUNCS*ROWS-1:0]      mask_q;
    logic                         gray_q;
    logic [CW-1:0]                cnt;

    logic [N_VARS-1:0]            code;
    logic [N_FUNCS-1:0]           row_bits;
    logic [N_FUNCS*CW-1:0]        count_nxt;
    logic [N_FUNCS-1:0]           taut_nxt;
    logic [N_FUNCS-1:0]           unsat_nxt;
    logic [ROWS-1:0]              slice;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: if (!hold && cnt == LAST_ROW) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt is one bit wider than the row index; only the low bits address the mask.
    always_comb begin
        code = cnt[N_VARS-1:0] ^ (gray_q ? (cnt[N_VARS-1:0] >> 1) : '0);
    end

    always_comb begin
        row_bits  = '0;
        count_nxt = '0;
        taut_nxt  = '0;
        unsat_nxt = '0;
        slice     = '0;
        for (int unsigned f = 0; f < N_FUNCS; f++) begin
            slice                   = mask_q[f*ROWS +: ROWS];
            row_bits[f]             = slice[code];
            count_nxt[f*CW +: CW]   = ones_count[f*CW +: CW] + {{N_VARS{1'b0}}, row_bits[f]};
            taut_nxt[f]             = (ones_count[f*CW +: CW] == FULL);
            unsat_nxt[f]            = (ones_count[f*CW +: CW] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            gray_q     <= 1'b0;
            cnt        <= '0;
            row_valid  <= 1'b0;
            row_in     <= '0;
            row_out    <= '0;
            done       <= 1'b0;
            ones_count <= '0;
            taut       <= '0;
            unsat      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mask_q     <= func_mask;
                        gray_q     <= gray_mode;
                        cnt        <= '0;
                        ones_count <= '0;
                        taut       <= '0;
                        unsat      <= '0;
                    end
                end
                SCAN: begin
                    if (hold) begin
                        row_valid <= 1'b0;
                    end else begin
                        row_in     <= code;
                        row_out    <= row_bits;
                        row_valid  <= 1'b1;
                        ones_count <= count_nxt;
                        cnt        <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    row_valid <= 1'b0;
                    done      <= 1'b1;
                    taut      <= taut_nxt;
                    unsat     <= unsat_nxt;
                end
                default: begin
                    row_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_scan_engine.sv
// Bench for minterm_scan_engine: directed scenarios with literal expectations plus randomized
// sweeps checked every cycle against a row-queue/visited-set model.
module tb_minterm_scan_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic        gray_mode;
    logic        hold;
    logic [39:0] func_mask;
    logic        busy;
    logic        row_valid;
    logic [2:0]  row_in;
    logic [4:0]  row_out;
    logic        done;
    logic [19:0] ones_count;
    logic [4:0]  taut;
    logic [4:0]  unsat;

    logic        start2;
    logic        gray2;
    logic        hold2;
    logic [15:0] mask2;
    logic        busy2;
    logic        rv2;
    logic [3:0]  ri2;
    logic [0:0]  ro2;
    logic        done2;
    logic [4:0]  oc2;
    logic [0:0]  taut2;
    logic [0:0]  unsat2;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] M = 40'h96_00_FF_15_0B;

    minterm_scan_engine #(.N_VARS(3), .N_FUNCS(5)) dut (
        .clk(clk), .reset(reset), .start(start), .gray_mode(gray_mode), .hold(hold),
        .func_mask(func_mask), .busy(busy), .row_valid(row_valid), .row_in(row_in),
        .row_out(row_out), .done(done), .ones_count(ones_count), .taut(taut), .unsat(unsat)
    );

    minterm_scan_engine #(.N_VARS(4), .N_FUNCS(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .gray_mode(gray2), .hold(hold2),
        .func_mask(mask2), .busy(busy2), .row_valid(rv2), .row_in(ri2),
        .row_out(ro2), .done(done2), .ones_count(oc2), .taut(taut2), .unsat(unsat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is a list of 8 row positions; visited minterms give the counts.
    bit          m_active = 0;
    int          m_pos = 0;
    logic [39:0] m_mask = '0;
    bit          m_gray = 0;
    logic [7:0]  m_visited = '0;
    logic        m_valid = 0;
    logic [2:0]  m_row_in = '0;
    logic [4:0]  m_row_out = '0;
    logic        m_done = 0;
    logic [4:0]  m_taut = '0;
    logic [4:0]  m_unsat = '0;

    function automatic int fcount(input logic [39:0] msk, input logic [7:0] sel, input int f);
        logic [7:0] s;
        s = msk[f*8 +: 8] & sel;
        return $countones(s);
    endfunction

    always @(posedge clk) begin
        int code;
        if (reset) begin
            m_active = 0; m_pos = 0; m_mask = '0; m_gray = 0; m_visited = '0;
            m_valid = 0; m_row_in = '0; m_row_out = '0; m_done = 0; m_taut = '0; m_unsat = '0;
        end else begin
            m_done = 0;
            if (m_active) begin
                if (m_pos < 8) begin
                    if (hold) begin
                        m_valid = 0;
                    end else begin
                        code = m_gray ? (m_pos ^ (m_pos >> 1)) : m_pos;
                        m_row_in = code[2:0];
                        for (int f = 0; f < 5; f++) m_row_out[f] = m_mask[f*8 + code];
                        m_visited[code] = 1'b1;
                        m_valid = 1;
                        m_pos++;
                    end
                end else begin
                    m_valid = 0;
                    m_done = 1;
                    m_active = 0;
                    for (int f = 0; f < 5; f++) begin
                        m_taut[f]  = (fcount(m_mask, 8'hFF, f) == 8);
                        m_unsat[f] = (fcount(m_mask, 8'hFF, f) == 0);
                    end
                end
            end else if (start) begin
                m_mask = func_mask; m_gray = gray_mode; m_pos = 0; m_visited = '0;
                m_taut = '0; m_unsat = '0; m_active = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [19:0] exp_cnt;
        for (int f = 0; f < 5; f++) exp_cnt[f*4 +: 4] = 4'(fcount(m_mask, m_visited, f));
        chk("busy", busy, m_active);
        chk("row_valid", row_valid, m_valid);
        chk("row_in", row_in, m_row_in);
        chk("row_out", row_out, m_row_out);
        chk("done", done, m_done);
        chk("ones_count", ones_count, exp_cnt);
        chk("taut", taut, m_taut);
        chk("unsat", unsat, m_unsat);
    end

    task automatic do_sweep(input logic [39:0] m, input logic g, input bit now,
                            input int hold_pos, input int hold_pct, input int spam_at,
                            input int spam_pct, input int reset_pos,
                            output int lat, output logic [23:0] seq, output logic [4:0] r2);
        int n, pos, hold_left;
        bit rnd;
        logic [63:0] t;
        if (!now) @(negedge clk);
        func_mask = m; gray_mode = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = {$urandom(), $urandom()};
        func_mask = t[39:0];
        n = 0; pos = 0; hold_left = 0; lat = -1; seq = '0; r2 = '0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (done) begin lat = n; break; end
            if (row_valid) begin
                if (pos < 8) seq[3*pos +: 3] = row_in;
                if (pos == 2) r2 = row_out;
                if (pos == reset_pos) begin
                    reset = 1'b1; hold = 1'b0; start = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    lat = -2;
                    break;
                end
                if (pos == hold_pos) hold_left = 3;
                pos++;
            end
            if (n == spam_at) begin
                start = 1'b1; func_mask = '0;
            end else begin
                start = (spam_pct > 0) && ($urandom_range(99) < spam_pct);
                t = {$urandom(), $urandom()};
                func_mask = t[39:0];
            end
            rnd = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
            hold = (hold_left > 0) || rnd;
            if (hold_left > 0) hold_left--;
        end
        hold = 1'b0;
        start = 1'b0;
        if (lat == -1) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, n, ones_rows, bad;
        bit seen, now;
        logic [23:0] seq;
        logic [4:0] r2;
        logic [63:0] t;

        reset = 1'b1; start = 1'b0; gray_mode = 1'b0; hold = 1'b0; func_mask = '0;
        start2 = 1'b0; gray2 = 1'b0; hold2 = 1'b0; mask2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ones_count", ones_count, 0);
        reset = 1'b0;

        // binary sweep
        do_sweep(M, 1'b0, 0, -1, 0, -1, 0, -1, lat, seq, r2);
        chk("t1_latency", lat, 9);
        chk("t1_seq", seq, 24'o76543210);
        chk("t1_row2_out", r2, 5'b10110);
        chk("t1_counts", ones_count, 20'h40833);
        chk("t1_taut", taut, 5'b00100);
        chk("t1_unsat", unsat, 5'b01000);

        // Gray sweep
        do_sweep(M, 1'b1, 0, -1, 0, -1, 0, -1, lat, seq, r2);
        chk("t2_latency", lat, 9);
        chk("t2_seq", seq, 24'o45762310);
        chk("t2_counts", ones_count, 20'h40833);
        chk("t2_taut", taut, 5'b00100);
        chk("t2_unsat", unsat, 5'b01000);

        // three hold cycles after row 3
        do_sweep(M, 1'b0, 0, 3, 0, -1, 0, -1, lat, seq, r2);
        chk("t3_latency", lat, 12);
        chk("t3_seq", seq, 24'o76543210);
        chk("t3_counts", ones_count, 20'h40833);

        // start with zero mask while busy is ignored
        do_sweep(M, 1'b0, 0, -1, 0, 2, 0, -1, lat, seq, r2);
        chk("t4_latency", lat, 9);
        chk("t4_counts", ones_count, 20'h40833);
        chk("t4_taut", taut, 5'b00100);

        // reset after row 4
        do_sweep(M, 1'b0, 0, -1, 0, -1, 0, 4, lat, seq, r2);
        chk("t5_busy", busy, 0);
        chk("t5_row_valid", row_valid, 0);
        chk("t5_ones_count", ones_count, 0);
        chk("t5_done", done, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("t5_no_done", seen, 0);
        do_sweep(M, 1'b0, 0, -1, 0, -1, 0, -1, lat, seq, r2);
        chk("t5_restart_latency", lat, 9);
        chk("t5_restart_counts", ones_count, 20'h40833);

        // 4-variable single-function instance
        @(negedge clk);
        mask2 = 16'h8000; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0; ones_rows = 0; bad = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (done2) break;
            if (rv2) begin
                if (ro2[0] != (ri2 == 4'd15)) bad++;
                if (ro2[0]) ones_rows++;
            end
        end
        chk("t6_latency", n, 17);
        chk("t6_row_errors", bad, 0);
        chk("t6_ones_rows", ones_rows, 1);
        chk("t6_count", oc2, 5'd1);
        chk("t6_taut", taut2, 1'b0);
        chk("t6_unsat", unsat2, 1'b0);

        // randomized sweeps; some start in the done cycle, some are cut by reset
        now = 0;
        for (int i = 0; i < 150; i++) begin
            t = {$urandom(), $urandom()};
            if ($urandom_range(9) == 0) t[39:32] = 8'hFF;
            if ($urandom_range(9) == 0) t[7:0] = 8'h00;
            do_sweep(t[39:0], 1'($urandom_range(1)), now, -1, $urandom_range(40), -1, 20,
                     ($urandom_range(14) == 0) ? int'($urandom_range(7)) : -1, lat, seq, r2);
            now = (lat > 0) && ($urandom_range(1) == 1);
        end
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
